// File: rtl/enc83_seq.sv
// Sequential priority encoder: captures a request vector and emits the index of
// every set bit, highest first, one index per accepted ready/valid handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing pending; a load with d!=0 starts a scan
//   SCAN  | q holds the highest pending index, v=busy=1, left counts down
module enc83_seq #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  input  logic         load,
  output logic [W-1:0] q,
  output logic         v,
  input  logic         rdy,
  output logic [W:0]   left,
  output logic         busy,
  output logic         nil
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t       state;
  logic [N-1:0] pend;
  logic [N-1:0] q_mask;
  logic [N-1:0] pend_rem;

  generate
    if (N != (1 << W) || N < 2 || N > 16) begin : g_bad_params
      $error("enc83_seq: N must be a power of two in 2..16 and equal 2**W");
    end
  endgenerate

  // Index of the most significant set bit; never called with x == 0.
  function automatic logic [W-1:0] enc(input logic [N-1:0] x);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) idx = W'(i);
    end
    return idx;
  endfunction

  function automatic logic [W:0] popcnt(input logic [N-1:0] x);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + (W+1)'(x[i]);
    end
    return c;
  endfunction

  always_comb begin
    q_mask    = '0;
    q_mask[q] = 1'b1;
    pend_rem  = pend & ~q_mask;
  end

  assign busy = (state == SCAN);
  assign v    = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      q     <= '0;
      left  <= '0;
      nil   <= 1'b0;
    end else begin
      nil <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (d != '0) begin
              pend  <= d;
              q     <= enc(d);
              left  <= popcnt(d);
              state <= SCAN;
            end else begin
              nil <= 1'b1;
            end
          end
        end
        SCAN: begin
          // load is deliberately ignored here, including on the final accept
          if (rdy) begin
            if (pend_rem != '0) begin
              pend <= pend_rem;
              q    <= enc(pend_rem);
              left <= left - (W+1)'(1);
            end else begin
              pend  <= '0;
              q     <= '0;
              left  <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc83_seq.sv
// Directed bench for enc83_seq: reset, burst, stall, empty load, load-while-busy
// and an exhaustive sweep over all 8-bit request vectors.
module tb_enc83_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] d;
  logic       load;
  logic [2:0] q;
  logic       v;
  logic       rdy;
  logic [3:0] left;
  logic       busy;
  logic       nil;

  int tests;
  int fails;

  enc83_seq #(.N(8), .W(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d),
    .load (load),
    .q    (q),
    .v    (v),
    .rdy  (rdy),
    .left (left),
    .busy (busy),
    .nil  (nil)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"}, 32'(v), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_left"}, 32'(left), 32'd0);
    chk({tag, "_q"}, 32'(q), 32'd0);
  endtask

  task automatic chk_scan(input string tag, input int exp_q, input int exp_left);
    chk({tag, "_v"}, 32'(v), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_left"}, 32'(left), 32'(exp_left));
  endtask

  initial begin
    int pc;
    int rem;
    logic [7:0] x;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    d     = 8'h00;
    load  = 1'b0;
    rdy   = 1'b0;

    // Reset state
    #2;
    chk_idle("reset");
    chk("reset_nil", 32'(nil), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a scan
    d = 8'hF0; load = 1'b1; rdy = 1'b0;
    tick();
    load = 1'b0;
    chk_scan("pre_rst", 7, 4);
    #2 rst_n = 1'b0;
    #1 chk_idle("async_rst");
    #1 rst_n = 1'b1;
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("post_rst");
    end

    // Burst with rdy held high
    d = 8'b1010_0100; load = 1'b1; rdy = 1'b1;
    tick();
    load = 1'b0;
    chk_scan("burst0", 7, 3);
    tick();
    chk_scan("burst1", 5, 2);
    tick();
    chk_scan("burst2", 2, 1);
    tick();
    chk_idle("burst_end");

    // Stall: data held stable while rdy is low
    d = 8'h81; load = 1'b1; rdy = 1'b0;
    tick();
    load = 1'b0;
    chk_scan("stall_first", 7, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_scan("stall_hold", 7, 2);
    end
    rdy = 1'b1;
    tick();
    chk_scan("stall_release", 0, 1);
    tick();
    chk_idle("stall_end");

    // Empty load pulses nil for one cycle
    d = 8'h00; load = 1'b1; rdy = 1'b0;
    tick();
    load = 1'b0;
    chk("nil_pulse", 32'(nil), 32'd1);
    chk_idle("nil_idle");
    tick();
    chk("nil_clear", 32'(nil), 32'd0);
    chk_idle("nil_after");

    // Load while busy is ignored
    d = 8'h01; load = 1'b1; rdy = 1'b0;
    tick();
    load = 1'b0;
    chk_scan("lwb_first", 0, 1);
    d = 8'hFF; load = 1'b1;
    tick();
    load = 1'b0;
    chk_scan("lwb_ignored", 0, 1);
    chk("lwb_nil", 32'(nil), 32'd0);
    rdy = 1'b1;
    tick();
    chk_idle("lwb_end");

    // Load on the final-accept edge is ignored, next cycle is honoured
    d = 8'h03; load = 1'b1; rdy = 1'b1;
    tick();
    load = 1'b0;
    chk_scan("fa0", 1, 2);
    tick();
    chk_scan("fa1", 0, 1);
    d = 8'hFF; load = 1'b1;
    tick();
    chk_idle("fa_ignored");
    d = 8'h10;
    tick();
    load = 1'b0;
    chk_scan("fa_honoured", 4, 1);
    tick();
    chk_idle("fa_end");

    // Exhaustive sweep with rdy high
    rdy = 1'b1;
    for (int n = 0; n < 256; n++) begin
      x = 8'(n);
      pc = 0;
      for (int b = 0; b < 8; b++) if (x[b]) pc++;
      d = x; load = 1'b1;
      tick();
      load = 1'b0;
      if (pc == 0) begin
        chk("ex_nil", 32'(nil), 32'd1);
        chk_idle("ex_zero");
      end else begin
        rem = pc;
        for (int b = 7; b >= 0; b--) begin
          if (x[b]) begin
            chk_scan($sformatf("ex_%02h_bit%0d", x, b), b, rem);
            rem--;
            tick();
          end
        end
        chk_idle($sformatf("ex_%02h_end", x));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enc83_seq.md
Name: enc83_seq

Overview:
Sequential 8-to-3 priority encoder. It is the inverse of the team's 2-to-4 and 3-to-8 decoders. It captures a one-hot or multi-hot request vector and emits the binary index of every set bit, highest index first, one index per accepted handshake. It sits between request-generating logic and any consumer that takes a binary select, for example a dcdr38 driving a one-hot enable.

Parameters:
N, 8, width of the request vector; power of two, 2..16
W, 3, index width; must equal log2(N)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
d  input  N  request vector; bit i set means index i is requested
load  input  1  capture d on this edge; honoured only when busy=0
q  output  W  encoded index of the current highest pending bit; registered
v  output  1  q is valid
rdy  input  1  consumer accepts q when v=1 and rdy=1 at the same edge
left  output  W+1  number of pending indices, including the one on q; 0 when idle
busy  output  1  high while the encoder is in the SCAN state
nil  output  1  one-cycle pulse when load is honoured with d=0

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: while rst_n=0, q=0, v=0, left=0, busy=0, nil=0, internal pend=0, state=IDLE. Reset takes effect immediately, not at the next edge. A reset during SCAN discards every pending index.
- State machine states: IDLE and SCAN. The outputs busy and v both equal (state==SCAN).
- Transitions from IDLE:
  - load=1 and d!=0: pend<=d, q<=enc(d), left<=popcount(d), move to SCAN. v goes high in the cycle after the load edge (latency 1).
  - load=1 and d=0: stay in IDLE, nil=1 for exactly one cycle, all other outputs unchanged.
  - load=0: hold.
- Transitions within SCAN:
  - v=1 and rdy=1 at an edge: clear bit q of pend, decrement left.
  - If the remaining pend is non-zero, q<=enc(remaining) and stay in SCAN with v=1.
  - If the remaining pend is zero, move to IDLE with v=0, q<=0, left<=0.
  - v=1 and rdy=0: q, left and pend hold stable. Data must not change while a transfer is stalled.
- Load while busy: load is ignored with no effect and nil stays 0. busy is sampled before the edge, so a load arriving on the same edge as the final accept is also ignored. A load one cycle later, once in IDLE, is honoured.
- Priority encoding: enc(x) returns the index of the most significant set bit of x. It is defined only for x!=0 and is never evaluated on 0.
- Throughput: with rdy held high, one index is emitted per cycle. A vector with k set bits keeps v high for exactly k cycles.
- Width rule: left is W+1 bits so it can hold N (for example 8 when d=8'hFF). left never wraps and never goes negative.
- Inputs: d is sampled only on an honoured load edge and ignored otherwise. rdy is ignored while v=0.

Test Plan:
1. Reset: drive rst_n=0 mid-SCAN, asynchronously between clock edges -> q=0, v=0, left=0, busy=0 immediately. After release, no stale index is emitted.
2. Burst: load d=8'b1010_0100 with rdy=1 held -> q=7,5,2 on three consecutive cycles with v=1 and left=3,2,1. In the fourth cycle v=0, busy=0, left=0.
3. Stall: load d=8'h81, rdy=0 for 4 cycles -> q=7, left=2, v=1 held stable. Raise rdy -> q=0, left=1 next cycle, then IDLE.
4. Empty load: load d=8'h00 in IDLE -> nil=1 for one cycle, v stays 0, busy stays 0.
5. Load while busy: load d=8'h01, then during SCAN with rdy=0 pulse load with d=8'hFF -> ignored. Only q=0 is emitted, then IDLE. Also pulse load on the final-accept edge -> ignored; load on the next cycle -> honoured.
6. Exhaustive: for all 256 d with rdy=1, the emitted q sequence equals the set-bit indices of d in descending order. The count of v=1 cycles equals popcount(d), and the initial left equals popcount(d). Includes d=8'hFF giving left=8 and eight outputs 7..0.
